// File: rtl/seq_decode_execute_if.sv
// rtl/seq_decode_execute_if.sv - command/result handshake bundle for seq_decode_execute
interface seq_decode_execute_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       sel;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] rd;
    logic             carry;
    logic             zero;

    modport master (
        output in_valid, sel, rs, rt, out_ready,
        input  in_ready, out_valid, rd, carry, zero
    );

    modport slave (
        input  in_valid, sel, rs, rt, out_ready,
        output in_ready, out_valid, rd, carry, zero
    );
endinterface

// File: rtl/seq_decode_execute.sv
// rtl/seq_decode_execute.sv - single-issue ALU with bit-serial shift/rotate and result handshake
module seq_decode_execute #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_decode_execute_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   cnt;
    logic             rot;
    logic [WIDTH-1:0] rd_q;
    logic             carry_q;
    logic             zero_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] alu_rd;
    logic             alu_c;
    logic             is_shift;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] work_nx;
    logic             accept;

    assign accept   = (state == IDLE) && bus.in_valid;
    assign is_shift = bus.sel[2] & ~bus.sel[1];
    // op 100 shifts rt by rs; op 101 rotates rs by rt
    assign shamt    = bus.sel[0] ? bus.rt[SHW-1:0] : bus.rs[SHW-1:0];
    assign work_nx  = rot ? {work[WIDTH-2:0], work[WIDTH-1]}
                          : {work[WIDTH-1], work[WIDTH-1:1]};

    always_comb begin
        sum    = {1'b0, bus.rs} + {1'b0, bus.rt};
        diff   = {1'b0, bus.rs} + {1'b0, ~bus.rt} + {{WIDTH{1'b0}}, 1'b1};
        alu_rd = '0;
        alu_c  = 1'b0;
        case (bus.sel)
            3'b000: begin alu_rd = diff[WIDTH-1:0]; alu_c = diff[WIDTH]; end
            3'b001: begin alu_rd = sum[WIDTH-1:0];  alu_c = sum[WIDTH];  end
            3'b010: alu_rd = bus.rs | bus.rt;
            3'b011: alu_rd = bus.rs & bus.rt;
            3'b100: alu_rd = bus.rt;
            3'b101: alu_rd = bus.rs;
            3'b110: alu_rd = {{(WIDTH-1){1'b0}}, (bus.rs < bus.rt)};
            default: alu_rd = {{(WIDTH-1){1'b0}}, (bus.rs == bus.rt)};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            work    <= '0;
            cnt     <= '0;
            rot     <= 1'b0;
            rd_q    <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_shift && shamt != '0) begin
                            state <= SHIFT;
                            work  <= alu_rd;
                            cnt   <= shamt;
                            rot   <= bus.sel[0];
                        end else begin
                            state   <= DONE;
                            rd_q    <= alu_rd;
                            carry_q <= alu_c;
                            zero_q  <= (alu_rd == '0);
                        end
                    end
                end
                SHIFT: begin
                    // rd stays at its old value until the final step lands
                    if (cnt == SHW'(1)) begin
                        state   <= DONE;
                        rd_q    <= work_nx;
                        carry_q <= 1'b0;
                        zero_q  <= (work_nx == '0);
                    end else begin
                        work <= work_nx;
                        cnt  <= cnt - SHW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.rd        = rd_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_seq_decode_execute.sv
// tb/tb_seq_decode_execute.sv - directed vector bench for seq_decode_execute
module tb_seq_decode_execute;
    localparam int W = 4;

    typedef struct {
        logic [2:0]   sel;
        logic [W-1:0] rs;
        logic [W-1:0] rt;
        logic [W-1:0] rd;
        logic         c;
        logic         z;
        int           edges;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs [15];

    always #5 clk = ~clk;

    seq_decode_execute_if #(.WIDTH(W)) bus ();
    seq_decode_execute #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input string name);
        int           edges;
        logic [W-1:0] prev_rd;
        bit           ok_hold;
        @(negedge clk);
        chk({name, " in_ready"}, int'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.sel = v.sel;
        bus.rs  = v.rs;
        bus.rt  = v.rt;
        prev_rd = bus.rd;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.sel = ~v.sel;
        bus.rs  = ~v.rs;
        bus.rt  = v.rt + 4'd1;
        @(negedge clk);
        edges   = 0;
        ok_hold = 1'b1;
        while (!bus.out_valid && edges < 20) begin
            if (bus.in_ready || bus.rd != prev_rd) ok_hold = 1'b0;
            @(negedge clk);
            edges++;
        end
        chk({name, " latency"}, edges, v.edges);
        chk({name, " rd"}, int'(bus.rd), int'(v.rd));
        chk({name, " carry"}, int'(bus.carry), int'(v.c));
        chk({name, " zero"}, int'(bus.zero), int'(v.z));
        if (v.edges > 0) chk({name, " shift_hold"}, int'(ok_hold), 1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({name, " out_valid_clr"}, int'(bus.out_valid), 0);
        chk({name, " in_ready_back"}, int'(bus.in_ready), 1);
    endtask

    initial begin
        vecs[0]  = '{3'b001, 4'd7,  4'd9,  4'd0,  1'b1, 1'b1, 0};
        vecs[1]  = '{3'b000, 4'd3,  4'd5,  4'hE,  1'b0, 1'b0, 0};
        vecs[2]  = '{3'b000, 4'd5,  4'd3,  4'd2,  1'b1, 1'b0, 0};
        vecs[3]  = '{3'b010, 4'h5,  4'hA,  4'hF,  1'b0, 1'b0, 0};
        vecs[4]  = '{3'b011, 4'hC,  4'hA,  4'h8,  1'b0, 1'b0, 0};
        vecs[5]  = '{3'b100, 4'd2,  4'b1000, 4'b1110, 1'b0, 1'b0, 2};
        vecs[6]  = '{3'b101, 4'b1001, 4'd3, 4'b1100, 1'b0, 1'b0, 3};
        vecs[7]  = '{3'b110, 4'd3,  4'd5,  4'd1,  1'b0, 1'b0, 0};
        vecs[8]  = '{3'b111, 4'hA,  4'hA,  4'd1,  1'b0, 1'b0, 0};
        vecs[9]  = '{3'b111, 4'd1,  4'd2,  4'd0,  1'b0, 1'b1, 0};
        vecs[10] = '{3'b100, 4'd0,  4'd5,  4'd5,  1'b0, 1'b0, 0};
        vecs[11] = '{3'b101, 4'd0,  4'd7,  4'd0,  1'b0, 1'b1, 3};
        vecs[12] = '{3'b100, 4'd1,  4'b1001, 4'b1100, 1'b0, 1'b0, 1};
        vecs[13] = '{3'b001, 4'd3,  4'd4,  4'd7,  1'b0, 1'b0, 0};
        vecs[14] = '{3'b000, 4'd4,  4'd4,  4'd0,  1'b1, 1'b1, 0};

        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.sel = 3'd0;
        bus.rs = '0;
        bus.rt = '0;
        repeat (2) @(negedge clk);
        chk("rst in_ready", int'(bus.in_ready), 1);
        chk("rst out_valid", int'(bus.out_valid), 0);
        chk("rst rd", int'(bus.rd), 0);
        chk("rst carry", int'(bus.carry), 0);
        chk("rst zero", int'(bus.zero), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) run(vecs[i], $sformatf("v%0d", i));

        // stall in DONE with a competing command on the inputs
        begin
            int waited;
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.sel = 3'b001;
            bus.rs = 4'd2;
            bus.rt = 4'd3;
            @(posedge clk);
            #1;
            bus.sel = 3'b010;
            bus.rs = 4'hF;
            bus.rt = 4'hF;
            waited = 0;
            @(negedge clk);
            while (!bus.out_valid && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            chk("stall latency", waited, 0);
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                chk($sformatf("stall rd c%0d", c), int'(bus.rd), 5);
                chk($sformatf("stall valid c%0d", c), int'(bus.out_valid), 1);
                chk($sformatf("stall in_ready c%0d", c), int'(bus.in_ready), 0);
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.in_valid = 1'b0;
            chk("stall release valid", int'(bus.out_valid), 0);
            chk("stall release in_ready", int'(bus.in_ready), 1);
            chk("stall release rd", int'(bus.rd), 5);
            repeat (2) @(negedge clk);
            chk("stall no queued cmd", int'(bus.out_valid), 0);
        end

        // reset in the middle of a 3-step rotate
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.sel = 3'b101;
        bus.rs = 4'd1;
        bus.rt = 4'd3;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midshift rst out_valid", int'(bus.out_valid), 0);
        chk("midshift rst rd", int'(bus.rd), 0);
        chk("midshift rst in_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        run('{3'b001, 4'd1, 4'd1, 4'd2, 1'b0, 1'b0, 0}, "post_rst add");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_decode_execute.md
SEQ_DECODE_EXECUTE -- requirements
Module: seq_decode_execute

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand and result width; legal values are powers of two, 4 or greater.
REQ-002 SHALL have localparam SHW = log2(WIDTH), the width of a shift amount.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  a command is presented on sel/rs/rt.
REQ-006 SHALL have port in_ready  output  1  the unit can accept a command this cycle.
REQ-007 SHALL have port sel  input  3  opcode.
REQ-008 SHALL have port rs  input  WIDTH  source operand A.
REQ-009 SHALL have port rt  input  WIDTH  source operand B.
REQ-010 SHALL have port out_valid  output  1  rd/carry/zero hold a valid result.
REQ-011 SHALL have port out_ready  input  1  the consumer takes the result this cycle.
REQ-012 SHALL have port rd  output  WIDTH  registered result.
REQ-013 SHALL have port carry  output  1  registered carry flag.
REQ-014 SHALL have port zero  output  1  registered flag, high when rd is 0.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT and DONE; in_ready SHALL be 1 exactly when the state is IDLE, and out_valid SHALL be 1 exactly when the state is DONE.
REQ-016 SHALL accept a command on a clock edge where in_valid=1 and in_ready=1, capturing sel, rs and rt; later changes to the inputs SHALL NOT affect that command.
REQ-017 SHALL use this opcode map (unsigned, modulo 2^WIDTH unless stated):
- 000: rd = rs - rt.
- 001: rd = rs + rt.
- 010: rd = rs OR rt.
- 011: rd = rs AND rt.
- 100: rd = rt arithmetic-shifted right by rs[SHW-1:0].
- 101: rd = rs rotated left by rt[SHW-1:0].
- 110: rd = {0..0, (rs < rt) unsigned}.
- 111: rd = {0..0, (rs == rt)}.
REQ-018 SHALL, for opcodes 000-011, 110 and 111, go IDLE->DONE on the accept edge, so out_valid is high in the cycle after acceptance (latency 1).
REQ-019 SHALL, for opcodes 100 and 101 with a shift amount k>0, go IDLE->SHIFT on the accept edge and move the working register one bit position per cycle.
REQ-020 SHALL leave SHIFT for DONE on the edge that completes the k-th step, so out_valid is high k cycles after the accept edge.
REQ-021 SHALL treat a shift with k=0 as a single-cycle operation: IDLE->DONE with rd equal to the unshifted operand.
REQ-022 SHALL hold rd, carry, zero and out_valid stable while in DONE with out_ready=0, with no timeout.
REQ-023 SHALL go DONE->IDLE on an edge where out_ready=1; out_valid SHALL be 0 and in_ready SHALL be 1 in the next cycle.
REQ-024 SHALL NOT accept a command in DONE, even in the same cycle as out_ready=1 (throughput is at most one command per two cycles).
REQ-025 SHALL ignore in_valid while in SHIFT or DONE; no command is queued.
REQ-026 SHALL set carry to the carry-out of rs+rt for 001, and of rs+~rt+1 (i.e. 1 when rs >= rt) for 000; carry SHALL be 0 for all other opcodes.
REQ-027 SHALL set zero to 1 exactly when the final rd is all zeros; zero and carry SHALL be updated on the same edge that enters DONE.
REQ-028 SHALL NOT make rd/carry/zero visibly change while in SHIFT; they SHALL hold the previous values until DONE is entered.
REQ-029 SHALL ignore out_ready while the state is not DONE.

Reset
REQ-030 SHALL, on rst_n=0 and asynchronously in any state including mid-SHIFT, force state=IDLE, rd=0, carry=0, zero=0 and out_valid=0 (in_ready=1).
REQ-031 SHALL abandon any in-flight command on reset and SHALL accept a new command on the first clock edge after rst_n returns to 1.

Verification (WIDTH=4)
REQ-032 SHALL cover: ADD rs=7, rt=9 -> rd=0, carry=1, zero=1, out_valid high in the cycle after accept.
REQ-033 SHALL cover: SUB rs=3, rt=5 -> rd=4'hE, carry=0; then SUB rs=5, rt=3 -> rd=2, carry=1.
REQ-034 SHALL cover: op 100 with rt=4'b1000, rs=2 -> in_ready low for 2 cycles, then rd=4'b1110 with out_valid high 2 cycles after accept; also op 101 with rs=4'b1001, rt=3 -> rd=4'b1100 after 3 cycles.
REQ-035 SHALL cover: LT rs=3, rt=5 -> rd=4'b0001; EQ rs=rt=4'hA -> rd=4'b0001; EQ rs=1, rt=2 -> rd=0, zero=1.
REQ-036 SHALL cover: out_ready held low for 5 cycles in DONE while in_valid=1 with new operands -> rd stable, in_ready=0, no new command accepted; then out_ready=1 -> IDLE next cycle.
REQ-037 SHALL cover: rst_n pulsed low during a k=3 shift -> out_valid=0, rd=0 at once; a fresh ADD 1+1 after release -> rd=2.
